jtag_axi_master_fsm: RTL and testbench

JTAG_AXI_MASTER_FSM -- requirements
Module: jtag_axi_master_fsm

---
 rtl/jtag_axi_pkg.sv | 76 +++++++
 rtl/jtag_axi_master_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_jtag_axi_master_fsm.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_axi_pkg.sv
// Shared types for the JTAG-to-AXI single-beat master.
// Widths come from `AXI_ADDR_WIDTH / `AXI_DATA_WIDTH (default 32).
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package jtag_axi_pkg;

   localparam int AXI_AW   = `AXI_ADDR_WIDTH;
   localparam int AXI_DW   = `AXI_DATA_WIDTH;
   localparam int AXI_SW   = AXI_DW / 8;
   localparam int AXI_IDW  = 4;
   localparam int MAX_SIZE = $clog2(AXI_SW);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_INCR = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_DATA
   } state_t;

   typedef enum logic [2:0] {
      IDLE_STATUS = 3'd0,
      RUNNING     = 3'd1,
      OKAY        = 3'd2,
      EXOKAY      = 3'd3,
      SLVERR      = 3'd4,
      DECERR      = 3'd5,
      TIMEOUT     = 3'd6
   } status_code_t;

   typedef enum logic {
      TXN_RD = 1'b0,
      TXN_WR = 1'b1
   } txn_type_t;

   typedef struct packed {
      txn_type_t         txn_type;
      logic [2:0]        size;
      logic [AXI_SW-1:0] strb;
   } s_axi_jtag_ctrl_t;

   typedef struct packed {
      logic [AXI_AW-1:0] addr;
      logic [AXI_DW-1:0] data_wr;
      s_axi_jtag_ctrl_t  ctrl;
   } s_axi_jtag_info_t;

   typedef struct packed {
      logic [AXI_DW-1:0] data_rd;
      status_code_t      code;
   } s_axi_jtag_status_t;

   function automatic status_code_t map_resp(input logic [1:0] resp);
      status_code_t c;
      case (resp)
         RESP_OKAY:   c = OKAY;
         RESP_EXOKAY: c = EXOKAY;
         RESP_SLVERR: c = SLVERR;
         default:     c = DECERR;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/jtag_axi_master_fsm.sv
// Single-beat AXI4 master driven by JTAG requests.
// Optional phase timeout enabled by defining JTAG_AXI_TIMEOUT_EN.
module jtag_axi_master_fsm
   import jtag_axi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  s_axi_jtag_info_t   req_i,
   output s_axi_jtag_status_t status_o,
   input  logic               status_rd_i,
   output logic               awvalid,
   input  logic               awready,
   output logic [AXI_AW-1:0]  awaddr,
   output logic [2:0]         awsize,
   output logic [2:0]         awprot,
   output logic [AXI_IDW-1:0] awid,
   output logic [7:0]         awlen,
   output logic [1:0]         awburst,
   output logic [3:0]         awcache,
   output logic               awlock,
   output logic               wvalid,
   input  logic               wready,
   output logic [AXI_DW-1:0]  wdata,
   output logic [AXI_SW-1:0]  wstrb,
   output logic               wlast,
   input  logic               bvalid,
   output logic               bready,
   input  logic [1:0]         bresp,
   output logic               arvalid,
   input  logic               arready,
   output logic [AXI_AW-1:0]  araddr,
   output logic [2:0]         arsize,
   output logic [2:0]         arprot,
   output logic [AXI_IDW-1:0] arid,
   output logic [7:0]         arlen,
   output logic [1:0]         arburst,
   output logic [3:0]         arcache,
   output logic               arlock,
   input  logic               rvalid,
   output logic               rready,
   input  logic [AXI_DW-1:0]  rdata,
   input  logic [1:0]         rresp,
   input  logic               rlast
);

   state_t             state, state_n;
   s_axi_jtag_info_t   req_q, req_n;
   s_axi_jtag_status_t status_q, status_n;
   logic               aw_done, aw_done_n;
   logic               w_done, w_done_n;
   logic               err_q, err_n;
   logic               accept;
   logic               busy;
   logic               unused_rlast;

   assign unused_rlast = rlast;

   assign busy   = (state != ST_IDLE);
   assign accept = req_valid_i && req_ready_o;

   assign req_ready_o = (state == ST_IDLE);
   assign status_o    = status_q;

   // Valids are pure register decodes, so the payload in req_q stays put.
   assign awvalid = (state == ST_WR_REQ) && !err_q && !aw_done;
   assign wvalid  = (state == ST_WR_REQ) && !err_q && !w_done;
   assign bready  = (state == ST_WR_RESP);
   assign arvalid = (state == ST_RD_REQ) && !err_q;
   assign rready  = (state == ST_RD_DATA);

   assign awaddr  = req_q.addr;
   assign awsize  = req_q.ctrl.size;
   assign awprot  = 3'b000;
   assign awid    = '0;
   assign awlen   = 8'd0;
   assign awburst = BURST_INCR;
   assign awcache = 4'd0;
   assign awlock  = 1'b0;
   assign wdata   = req_q.data_wr;
   assign wstrb   = req_q.ctrl.strb;
   assign wlast   = 1'b1;

   assign araddr  = req_q.addr;
   assign arsize  = req_q.ctrl.size;
   assign arprot  = 3'b000;
   assign arid    = '0;
   assign arlen   = 8'd0;
   assign arburst = BURST_INCR;
   assign arcache = 4'd0;
   assign arlock  = 1'b0;

`ifdef JTAG_AXI_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] cnt;
   logic          expired;

   assign expired = busy && (cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || (state_n != state)) begin
         cnt <= '0;
      end else if (busy) begin
         cnt <= cnt + 1'b1;
      end
   end
`endif

   always_comb begin
      state_n   = state;
      req_n     = req_q;
      status_n  = status_q;
      aw_done_n = aw_done;
      w_done_n  = w_done;
      err_n     = err_q;
      unique case (state)
         ST_IDLE: begin
            // An accept wins over a simultaneous status read.
            if (accept) begin
               req_n         = req_i;
               err_n         = (req_i.ctrl.size > 3'(MAX_SIZE));
               aw_done_n     = 1'b0;
               w_done_n      = 1'b0;
               status_n.code = RUNNING;
               if (req_i.ctrl.txn_type == TXN_WR) begin
                  state_n = ST_WR_REQ;
               end else begin
                  state_n = ST_RD_REQ;
               end
            end else if (status_rd_i) begin
               status_n.code = IDLE_STATUS;
            end
         end
         ST_WR_REQ: begin
            if (err_q) begin
               status_n.code = SLVERR;
               state_n       = ST_IDLE;
            end else begin
               aw_done_n = aw_done || (awvalid && awready);
               w_done_n  = w_done || (wvalid && wready);
               if (aw_done_n && w_done_n) begin
                  state_n = ST_WR_RESP;
               end
            end
         end
         ST_WR_RESP: begin
            if (bvalid) begin
               status_n.code = map_resp(bresp);
               state_n       = ST_IDLE;
            end
         end
         ST_RD_REQ: begin
            if (err_q) begin
               status_n.code = SLVERR;
               state_n       = ST_IDLE;
            end else if (arready) begin
               state_n = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            if (rvalid) begin
               status_n.data_rd = rdata;
               status_n.code    = map_resp(rresp);
               state_n          = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
`ifdef JTAG_AXI_TIMEOUT_EN
      if (expired && (state_n == state)) begin
         status_n.code = TIMEOUT;
         state_n       = ST_IDLE;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         req_q    <= '0;
         status_q <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         req_q    <= req_n;
         status_q <= status_n;
         aw_done  <= aw_done_n;
         w_done   <= w_done_n;
         err_q    <= err_n;
      end
   end

endmodule

// File: tb/tb_jtag_axi_master_fsm.sv
// Directed testbench for jtag_axi_master_fsm.
// Covers write/read paths, status ack, size error, reset and timeout.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module tb_jtag_axi_master_fsm;
   import jtag_axi_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               req_valid_i;
   logic               req_ready_o;
   s_axi_jtag_info_t   req_i;
   s_axi_jtag_status_t status_o;
   logic               status_rd_i;
   logic               awvalid, awready, awlock;
   logic [AXI_AW-1:0]  awaddr, araddr;
   logic [2:0]         awsize, awprot, arsize, arprot;
   logic [AXI_IDW-1:0] awid, arid;
   logic [7:0]         awlen, arlen;
   logic [1:0]         awburst, arburst;
   logic [3:0]         awcache, arcache;
   logic               wvalid, wready, wlast;
   logic [AXI_DW-1:0]  wdata, rdata;
   logic [AXI_SW-1:0]  wstrb;
   logic               bvalid, bready;
   logic [1:0]         bresp, rresp;
   logic               arvalid, arready, arlock;
   logic               rvalid, rready, rlast;

   int checks = 0;
   int errors = 0;
   int aw_cnt = 0;
   int w_cnt  = 0;
   int ar_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (awvalid && awready) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready)   w_cnt  <= w_cnt + 1;
      if (arvalid && arready) ar_cnt <= ar_cnt + 1;
   end

   jtag_axi_master_fsm #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_i(req_i), .status_o(status_o), .status_rd_i(status_rd_i),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .awsize(awsize), .awprot(awprot), .awid(awid), .awlen(awlen),
      .awburst(awburst), .awcache(awcache), .awlock(awlock),
      .wvalid(wvalid), .wready(wready), .wdata(wdata),
      .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .arsize(arsize), .arprot(arprot), .arid(arid), .arlen(arlen),
      .arburst(arburst), .arcache(arcache), .arlock(arlock),
      .rvalid(rvalid), .rready(rready), .rdata(rdata),
      .rresp(rresp), .rlast(rlast)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic s_axi_jtag_info_t mk_req(
      input txn_type_t t, input logic [31:0] a,
      input logic [31:0] d, input logic [2:0] sz);
      s_axi_jtag_info_t r;
      r = '0;
      r.addr          = AXI_AW'(a);
      r.data_wr       = AXI_DW'(d);
      r.ctrl.txn_type = t;
      r.ctrl.size     = sz;
      r.ctrl.strb     = '1;
      return r;
   endfunction

   task automatic idle_slave();
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 1;
   endtask

   task automatic test_reset();
      rst = 1; req_valid_i = 0; status_rd_i = 0; req_i = '0;
      idle_slave();
      tick(); tick();
      rst = 0;
      checks++;
      if (req_ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", req_ready_o);
      end
      checks++;
      if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
         errors++;
         $display("FAIL reset_valids: got %b want 00000",
                  {awvalid, wvalid, bready, arvalid, rready});
      end
      checks++;
      if (status_o !== '0) begin
         errors++; $display("FAIL reset_status: got %h want 0", status_o);
      end
   endtask

   task automatic test_write();
      int a0, w0;
      a0 = aw_cnt; w0 = w_cnt;
      req_i = mk_req(TXN_WR, 32'h1000, 32'hDEADBEEF, 3'd2);
      req_valid_i = 1;
      tick();
      req_valid_i = 0;
      wready = 1;
      checks++;
      if (status_o.code !== RUNNING) begin
         errors++; $display("FAIL wr_running: got %0d want %0d",
                            status_o.code, RUNNING);
      end
      checks++;
      if ({awvalid, wvalid} !== 2'b11) begin
         errors++; $display("FAIL wr_valids: got %b want 11", {awvalid, wvalid});
      end
      checks++;
      if (awaddr !== AXI_AW'(32'h1000) || wdata !== AXI_DW'(32'hDEADBEEF)
          || wstrb !== 4'hF || awsize !== 3'd2 || wlast !== 1'b1) begin
         errors++; $display("FAIL wr_payload: got %h %h %h %0d want 1000 deadbeef f 2",
                            awaddr, wdata, wstrb, awsize);
      end
      tick();
      wready = 0;
      checks++;
      if ({awvalid, wvalid} !== 2'b10) begin
         errors++; $display("FAIL wr_w_drop: got %b want 10", {awvalid, wvalid});
      end
      tick();
      awready = 1;
      tick();
      awready = 0;
      checks++;
      if ({awvalid, bready} !== 2'b01) begin
         errors++; $display("FAIL wr_resp_phase: got %b want 01", {awvalid, bready});
      end
      bvalid = 1; bresp = RESP_OKAY;
      tick();
      bvalid = 0;
      checks++;
      if (status_o.code !== OKAY || req_ready_o !== 1'b1) begin
         errors++; $display("FAIL wr_okay: got %0d/%b want %0d/1",
                            status_o.code, req_ready_o, OKAY);
      end
      checks++;
      if (aw_cnt - a0 != 1 || w_cnt - w0 != 1) begin
         errors++; $display("FAIL wr_hs_count: got aw=%0d w=%0d want 1 1",
                            aw_cnt - a0, w_cnt - w0);
      end
   endtask

   task automatic test_aw_first();
      int a0, w0;
      a0 = aw_cnt; w0 = w_cnt;
      req_i = mk_req(TXN_WR, 32'h3000, 32'h55AA55AA, 3'd2);
      req_valid_i = 1;
      tick();
      req_valid_i = 0;
      awready = 1;
      tick();
      awready = 0;
      checks++;
      if ({awvalid, wvalid} !== 2'b01) begin
         errors++; $display("FAIL awfirst_drop: got %b want 01", {awvalid, wvalid});
      end
      wready = 1;
      tick();
      wready = 0;
      bvalid = 1; bresp = RESP_DECERR;
      tick();
      bvalid = 0;
      checks++;
      if (status_o.code !== DECERR || aw_cnt - a0 != 1 || w_cnt - w0 != 1) begin
         errors++; $display("FAIL awfirst_done: got code=%0d aw=%0d w=%0d want %0d 1 1",
                            status_o.code, aw_cnt - a0, w_cnt - w0, DECERR);
      end
   endtask

   task automatic test_read();
      req_i = mk_req(TXN_RD, 32'h2000, 32'h0, 3'd2);
      req_valid_i = 1;
      tick();
      req_valid_i = 0;
      checks++;
      if (arvalid !== 1'b1 || araddr !== AXI_AW'(32'h2000) || arsize !== 3'd2) begin
         errors++; $display("FAIL rd_ar: got %b %h want 1 2000", arvalid, araddr);
      end
      arready = 1;
      tick();
      arready = 0;
      checks++;
      if ({arvalid, rready} !== 2'b01) begin
         errors++; $display("FAIL rd_phase: got %b want 01", {arvalid, rready});
      end
      rvalid = 1; rdata = AXI_DW'(32'h12345678); rresp = RESP_SLVERR;
      tick();
      rvalid = 0;
      checks++;
      if (status_o.data_rd !== AXI_DW'(32'h12345678) || status_o.code !== SLVERR) begin
         errors++; $display("FAIL rd_status: got %h/%0d want 12345678/%0d",
                            status_o.data_rd, status_o.code, SLVERR);
      end
      checks++;
      if (req_ready_o !== 1'b1) begin
         errors++; $display("FAIL rd_ready: got %b want 1", req_ready_o);
      end
   endtask

   task automatic test_status_rd();
      status_rd_i = 1;
      tick();
      status_rd_i = 0;
      checks++;
      if (status_o.code !== IDLE_STATUS || status_o.data_rd !== AXI_DW'(32'h12345678)) begin
         errors++; $display("FAIL status_ack: got %0d/%h want 0/12345678",
                            status_o.code, status_o.data_rd);
      end
   endtask

   task automatic test_back_to_back();
      int a0, w0, r0;
      a0 = aw_cnt; w0 = w_cnt; r0 = ar_cnt;
      req_i = mk_req(TXN_WR, 32'h4000, 32'h0BADF00D, 3'd2);
      req_valid_i = 1;
      tick();
      req_valid_i = 0;
      awready = 1; wready = 1;
      tick();
      awready = 0; wready = 0;
      checks++;
      if (bready !== 1'b1) begin
         errors++; $display("FAIL b2b_same_cycle: got bready=%b want 1", bready);
      end
      bvalid = 1; bresp = RESP_EXOKAY;
      tick();
      bvalid = 0;
      checks++;
      if (status_o.code !== EXOKAY) begin
         errors++; $display("FAIL b2b_exokay: got %0d want %0d", status_o.code, EXOKAY);
      end
      req_i = mk_req(TXN_RD, 32'h5000, 32'h0, 3'd1);
      req_valid_i = 1; status_rd_i = 1;
      tick();
      req_valid_i = 0; status_rd_i = 0;
      checks++;
      if (status_o.code !== RUNNING || arvalid !== 1'b1) begin
         errors++; $display("FAIL b2b_running: got %0d/%b want %0d/1",
                            status_o.code, arvalid, RUNNING);
      end
      arready = 1;
      tick();
      arready = 0;
      rvalid = 1; rdata = AXI_DW'(32'hCAFEF00D); rresp = RESP_OKAY;
      tick();
      rvalid = 0;
      checks++;
      if (status_o.code !== OKAY || status_o.data_rd !== AXI_DW'(32'hCAFEF00D)) begin
         errors++; $display("FAIL b2b_read: got %0d/%h want %0d/cafef00d",
                            status_o.code, status_o.data_rd, OKAY);
      end
      checks++;
      if (aw_cnt - a0 != 1 || w_cnt - w0 != 1 || ar_cnt - r0 != 1) begin
         errors++; $display("FAIL b2b_count: got %0d %0d %0d want 1 1 1",
                            aw_cnt - a0, w_cnt - w0, ar_cnt - r0);
      end
   endtask

   task automatic test_size_err();
      int a0, w0;
      a0 = aw_cnt; w0 = w_cnt;
      req_i = mk_req(TXN_WR, 32'h6000, 32'h1, 3'd3);
      req_valid_i = 1;
      awready = 1; wready = 1;
      tick();
      req_valid_i = 0;
      checks++;
      if ({awvalid, wvalid} !== 2'b00 || status_o.code !== RUNNING) begin
         errors++; $display("FAIL size_quiet: got %b/%0d want 00/%0d",
                            {awvalid, wvalid}, status_o.code, RUNNING);
      end
      tick();
      awready = 0; wready = 0;
      checks++;
      if (status_o.code !== SLVERR || req_ready_o !== 1'b1
          || aw_cnt != a0 || w_cnt != w0) begin
         errors++; $display("FAIL size_err: got %0d/%b aw=%0d w=%0d want %0d/1 0 0",
                            status_o.code, req_ready_o, aw_cnt - a0, w_cnt - w0, SLVERR);
      end
   endtask

   task automatic test_reset_mid();
      req_i = mk_req(TXN_RD, 32'h7000, 32'h0, 3'd2);
      req_valid_i = 1;
      tick();
      req_valid_i = 0;
      arready = 1;
      tick();
      arready = 0;
      checks++;
      if (rready !== 1'b1) begin
         errors++; $display("FAIL mid_rd_data: got rready=%b want 1", rready);
      end
      rst = 1;
      tick();
      rst = 0;
      checks++;
      if (rready !== 1'b0 || req_ready_o !== 1'b1 || status_o !== '0) begin
         errors++; $display("FAIL mid_reset: got %b/%b/%h want 0/1/0",
                            rready, req_ready_o, status_o);
      end
   endtask

   task automatic test_timeout();
      req_i = mk_req(TXN_WR, 32'h8000, 32'h2, 3'd2);
      req_valid_i = 1;
      tick();
      req_valid_i = 0;
`ifdef JTAG_AXI_TIMEOUT_EN
      for (int i = 0; i < 15; i++) tick();
      checks++;
      if (awvalid !== 1'b1 || status_o.code !== RUNNING) begin
         errors++; $display("FAIL tmo_early: got %b/%0d want 1/%0d",
                            awvalid, status_o.code, RUNNING);
      end
      tick();
      checks++;
      if (status_o.code !== TIMEOUT || {awvalid, wvalid} !== 2'b00
          || req_ready_o !== 1'b1) begin
         errors++; $display("FAIL tmo_fire: got %0d/%b/%b want %0d/00/1",
                            status_o.code, {awvalid, wvalid}, req_ready_o, TIMEOUT);
      end
`else
      for (int i = 0; i < 1000; i++) tick();
      checks++;
      if ({awvalid, wvalid} !== 2'b11 || status_o.code !== RUNNING) begin
         errors++; $display("FAIL no_tmo: got %b/%0d want 11/%0d",
                            {awvalid, wvalid}, status_o.code, RUNNING);
      end
      rst = 1;
      tick();
      rst = 0;
`endif
   endtask

   initial begin
      test_reset();
      test_write();
      test_aw_first();
      test_read();
      test_status_rd();
      test_back_to_back();
      test_size_err();
      test_reset_mid();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
